reg_file_mp: RTL
================

// Module: reg_file_mp
// PURPOSE
//  Parametrised multi-port general-purpose register file for the pipelined MIPS core.
//  - Configurable width, depth and read-port count.
//  - Two write ports: W0 for ALU writeback, W1 for load writeback.
//  - Optional write-to-read bypass.
//  - Per-register busy scoreboard used by the hazard unit to stall on pending producers.
//  - Sits between decode (reads, scoreboard set) and writeback (writes, scoreboard clear).
// PARAMETERS
//  DATA_W    32  register width in bits
//  DEPTH     32  number of registers (>=2)
//  ADDR_W    $clog2(DEPTH)  address width; derived, do not override
//  NUM_RD    2   number of read ports (1..4)
//  BYPASS    1   1: same-cycle write data is visible on reads; 0: reads show stored value only
//  ZERO_REG  1   1: register 0 reads 0, ignores writes, never busy
// PORTS
//  clk         in   1              rising-edge clock
//  rst_n       in   1              asynchronous active-low reset
//  rd_addr     in   NUM_RD*ADDR_W  packed read addresses; port k = [k*ADDR_W +: ADDR_W]
//  rd_data     out  NUM_RD*DATA_W  packed read data, combinational
//  rd_busy     out  NUM_RD         busy flag of the register addressed by each read port
//  wr0_en      in   1              write enable, port 0
//  wr0_addr    in   ADDR_W         write address, port 0
//  wr0_data    in   DATA_W         write data, port 0
//  wr1_en      in   1              write enable, port 1 (priority port)
//  wr1_addr    in   ADDR_W         write address, port 1
//  wr1_data    in   DATA_W         write data, port 1
//  sb_set_en   in   1              mark a register as having a pending producer
//  sb_set_addr in   ADDR_W         register to mark busy
//  busy_vec    out  DEPTH          full scoreboard state, registered
// BEHAVIOUR
//  Reset
//  - One clock. Reset is asynchronous and active-low: rst_n=0 immediately clears every register to 0 and every busy bit to 0.
//  - Reset mid-operation discards pending writes and sets. Outputs read 0 and not-busy while rst_n=0.
//  Writes
//  - Register update at the rising edge of clk when wrX_en=1.
//  - Both ports writing the same address in one cycle: W1 data is stored.
//  - Write ignored when the address is >= DEPTH.
//  - Write ignored when the address is 0 and ZERO_REG=1.
//  Reads
//  - Combinational.
//  - Address 0 with ZERO_REG=1 reads 0.
//  - Address >= DEPTH reads 0.
//  - BYPASS=1: a read address that matches an enabled, valid write this cycle returns that write data (W1 over W0). Read latency is 0 cycles relative to writeback.
//  - BYPASS=0: the read returns the stored value; the new value is visible the next cycle.
//  Scoreboard
//  - At the clock edge, sb_set_en sets busy[sb_set_addr].
//  - At the clock edge, any enabled valid write clears busy[wr_addr].
//  - Set and clear of the same address in one cycle: set wins. The new producer supersedes the retiring one.
//  - busy[0] stays 0 when ZERO_REG=1. A set to an address >= DEPTH is ignored.
//  - rd_busy[k] = busy[rd_addr k]. When BYPASS=1, it is forced to 0 if the register is written this cycle and not being re-set in the same cycle.
//  - busy_vec shows the registered state only, with no bypass.
//  Widths
//  - No arithmetic. All data paths are exactly DATA_W bits; no sign or zero extension inside.
// STRUCTURE
//  Shared package (core_pkg)
//  - Constants DATA_W_DEF=32, DEPTH_DEF=32, REG_ZERO=0.
//  - typedef reg_addr_t.
//  Sub-module rf_read_mux
//  - Instantiated once per read port via generate.
//  - Address decode, zero/range masking, bypass compare and priority selection.
//  Top level
//  - Holds the storage array, the scoreboard flops and the write decode.
// TESTING
//  1. Reset: assert rst_n=0 mid-simulation after writes -> all rd_data=0 and busy_vec=0 asynchronously, without waiting for clk.
//  2. Write/read:
//     - wr0 r5=32'hDEADBEEF -> next cycle rd_addr0=5 gives DEADBEEF.
//     - Write r0=32'h1234 -> r0 reads 0.
//  3. Port collision: wr0 r7=32'h1111 and wr1 r7=32'h2222 in the same cycle -> r7 reads 32'h2222.
//  4. Bypass with BYPASS=1: wr1 r9=32'hCAFE while rd_addr1=9 -> rd_data1=CAFE in the same cycle. With BYPASS=0, the old value in the same cycle and CAFE the next cycle.
//  5. Scoreboard:
//     - sb_set r3 -> busy_vec[3]=1 next cycle.
//     - wr0 r3 -> busy_vec[3]=0 next cycle.
//     - sb_set r3 together with wr0 r3 -> busy_vec[3] stays 1.
//     - sb_set r0 -> busy_vec[0]=0.
//  6. Params DEPTH=24, NUM_RD=4: write r30 ignored, reads of 30 give 0, all 4 ports read independent addresses correctly.

Source files
------------

// File: rtl/reg_file_mp_pkg.sv
// Shared constants, address type and address qualification helper for the
// multi-port register file.
package reg_file_mp_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 32;
  localparam int REG_ZERO   = 0;

  typedef logic [$clog2(DEPTH_DEF)-1:0] reg_addr_t;

  // An address names a real, writable/readable register: inside the array and
  // not the hard-wired zero register.
  function automatic logic addr_ok(input logic [31:0] addr,
                                   input int unsigned depth,
                                   input logic zero_reg);
    logic in_range;
    logic is_zero;
    in_range = (addr < depth);
    is_zero  = zero_reg && (addr == 32'(REG_ZERO));
    return in_range && !is_zero;
  endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Decode/writeback side bus of the register file: read ports, two write
// ports, scoreboard set and the scoreboard view.
interface reg_file_mp_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr0_en;
  logic [ADDR_W-1:0]        wr0_addr;
  logic [DATA_W-1:0]        wr0_data;
  logic                     wr1_en;
  logic [ADDR_W-1:0]        wr1_addr;
  logic [DATA_W-1:0]        wr1_data;
  logic                     sb_set_en;
  logic [ADDR_W-1:0]        sb_set_addr;
  logic [DEPTH-1:0]         busy_vec;

  modport master (
    output rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
           sb_set_en, sb_set_addr,
    input  rd_data, rd_busy, busy_vec
  );

  modport slave (
    input  rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
           sb_set_en, sb_set_addr,
    output rd_data, rd_busy, busy_vec
  );
endinterface

// File: rtl/reg_file_mp_rf_read_mux.sv
// One combinational read port: range/zero masking, optional write bypass
// (W1 over W0) and the matching busy flag.
module reg_file_mp_rf_read_mux
  import reg_file_mp_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] regs [DEPTH],
  input  logic [DEPTH-1:0]  busy_q,
  input  logic              w0_valid,
  input  logic [ADDR_W-1:0] w0_addr,
  input  logic [DATA_W-1:0] w0_data,
  input  logic              w1_valid,
  input  logic [ADDR_W-1:0] w1_addr,
  input  logic [DATA_W-1:0] w1_data,
  input  logic              set_valid,
  input  logic [ADDR_W-1:0] set_addr,
  output logic [DATA_W-1:0] data,
  output logic              busy
);

  logic w0_hit;
  logic w1_hit;
  logic set_hit;

  // Write valids already exclude out-of-range, zero-register and reset cases.
  assign w0_hit  = w0_valid  && (w0_addr  == addr);
  assign w1_hit  = w1_valid  && (w1_addr  == addr);
  assign set_hit = set_valid && (set_addr == addr);

  // Select stored or bypassed data and busy for this port.
  always_comb begin
    data = '0;
    busy = 1'b0;
    if (addr_ok(32'(addr), DEPTH, ZERO_REG != 0)) begin
      data = regs[addr];
      busy = busy_q[addr];
      if (BYPASS != 0) begin
        if (w1_hit) begin
          data = w1_data;
        end else if (w0_hit) begin
          data = w0_data;
        end else begin
          data = regs[addr];
        end
        // A retiring producer frees the register unless a new one claims it.
        if ((w0_hit || w1_hit) && !set_hit) begin
          busy = 1'b0;
        end else begin
          busy = busy_q[addr];
        end
      end else begin
        data = regs[addr];
      end
    end else begin
      data = '0;
      busy = 1'b0;
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port GPR file: storage array, busy scoreboard, write decode and one
// read mux per read port.
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input logic          clk,
  input logic          rst_n,
  reg_file_mp_if.slave bus
);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic              w0_valid;
  logic              w1_valid;
  logic              set_valid;

  // Qualified write/set requests; gating with rst_n keeps the bypass path
  // quiet while the array is held in reset.
  always_comb begin
    w0_valid  = rst_n && bus.wr0_en    && addr_ok(32'(bus.wr0_addr),    DEPTH, ZERO_REG != 0);
    w1_valid  = rst_n && bus.wr1_en    && addr_ok(32'(bus.wr1_addr),    DEPTH, ZERO_REG != 0);
    set_valid = rst_n && bus.sb_set_en && addr_ok(32'(bus.sb_set_addr), DEPTH, ZERO_REG != 0);
  end

  // Storage and scoreboard update; W1 wins a write collision, set wins over clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w1_valid && (bus.wr1_addr == ADDR_W'(i))) begin
          regs[i] <= bus.wr1_data;
        end else if (w0_valid && (bus.wr0_addr == ADDR_W'(i))) begin
          regs[i] <= bus.wr0_data;
        end else begin
          regs[i] <= regs[i];
        end
        if (set_valid && (bus.sb_set_addr == ADDR_W'(i))) begin
          busy_q[i] <= 1'b1;
        end else if ((w0_valid && (bus.wr0_addr == ADDR_W'(i))) ||
                     (w1_valid && (bus.wr1_addr == ADDR_W'(i)))) begin
          busy_q[i] <= 1'b0;
        end else begin
          busy_q[i] <= busy_q[i];
        end
      end
    end
  end

  assign bus.busy_vec = busy_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    reg_file_mp_rf_read_mux #(
      .DATA_W  (DATA_W),
      .DEPTH   (DEPTH),
      .ADDR_W  (ADDR_W),
      .BYPASS  (BYPASS),
      .ZERO_REG(ZERO_REG)
    ) u_mux (
      .addr     (bus.rd_addr[k*ADDR_W +: ADDR_W]),
      .regs     (regs),
      .busy_q   (busy_q),
      .w0_valid (w0_valid),
      .w0_addr  (bus.wr0_addr),
      .w0_data  (bus.wr0_data),
      .w1_valid (w1_valid),
      .w1_addr  (bus.wr1_addr),
      .w1_data  (bus.wr1_data),
      .set_valid(set_valid),
      .set_addr (bus.sb_set_addr),
      .data     (bus.rd_data[k*DATA_W +: DATA_W]),
      .busy     (bus.rd_busy[k])
    );
  end

endmodule
